hdmi_period_sched: RTL and testbench
====================================

Name: hdmi_period_sched

Overview:
- Sequencing controller for the 640x480@60 TMDS transmit path.
- Owns the horizontal and vertical pixel counters and emits the following per pixel:
  - HDMI period type: control, video preamble, video guard band or active video.
  - The 6 CTL/sync bits for the three TMDS encoders.
  - The active-pixel coordinates for the pattern source.
- Runs in the TMDS bit-clock domain and advances on a one-in-ten pixel clock enable.
- Start/stop handshake: frames begin cleanly on enable and always end on a frame boundary.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels after active)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, asserted level of hsync/vsync (0 = negative)
- PRE_LEN, 8, video preamble length in pixels
- GB_LEN, 2, video guard band length in pixels

Ports:
- clk_in  in  1  TMDS bit clock (252 MHz); the only clock
- rst_in  in  1  synchronous, active-low reset
- pix_ce  in  1  pixel clock enable, one cycle in ten
- enable  in  1  request to run frames (level)
- busy  out  1  high while frames are being generated (RUN or DRAIN)
- frame_start  out  1  one-clk_in pulse on the pix_ce where x=0, y=0 is entered
- mode  out  2  0=CTRL, 1=PREAMBLE, 2=GUARD, 3=VIDEO
- ctl  out  6  {ch2 CTL3:CTL2, ch1 CTL1:CTL0, ch0 vsync:hsync}
- pix_x  out  10  active x (0..639); 0 outside VIDEO
- pix_y  out  10  active y (0..479); 0 outside VIDEO

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H parameters = 800.
  - V_TOTAL = sum of the V parameters = 525.
- Counters x and y are 10 bits wide.
  - x wraps H_TOTAL-1 -> 0.
  - y increments when x wraps, and wraps V_TOTAL-1 -> 0.
- Every state, counter and output register updates only on clk_in edges with pix_ce=1. With pix_ce=0, everything holds, except frame_start, which clears.
- Outputs are registered and decoded from the next (x, y), so outputs always describe the pixel currently held in the counters. Latency is zero pix_ce relative to the counters.
- Reset (rst_in=0 at a clk_in edge, regardless of pix_ce):
  - state=IDLE, x=0, y=0, busy=0, frame_start=0, mode=CTRL, pix_x=0, pix_y=0.
  - ctl = {2'b00, 2'b00, ~SYNC_POL, ~SYNC_POL}.
  - Reset mid-frame aborts immediately; there is no drain.
- FSM states:
  - IDLE: counters held at 0, outputs at reset values. On a pix_ce with enable=1, go to RUN. That same pix_ce loads x=0, y=0, pulses frame_start and sets busy=1.
  - RUN: counters advance. If enable=0 on a pix_ce, go to DRAIN (counters keep advancing).
  - DRAIN: identical outputs to RUN.
    - If enable=1 again, return to RUN with no discontinuity.
    - On the pix_ce where (x, y) = (H_TOTAL-1, V_TOTAL-1) would wrap, go to IDLE instead of wrapping.
  - RUN at that same wrap point with enable=1 wraps to (0, 0) and pulses frame_start.
- Sync decode (RUN/DRAIN):
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Both are ~SYNC_POL otherwise.
- Next-line-active flag: ny = (y==V_TOTAL-1) ? 0 : y+1; nla = (ny < V_ACTIVE).
- Mode priority:
  - VIDEO if x < H_ACTIVE and y < V_ACTIVE.
  - else GUARD if nla and x >= H_TOTAL-GB_LEN.
  - else PREAMBLE if nla and x >= H_TOTAL-GB_LEN-PRE_LEN.
  - else CTRL.
- CTL bits:
  - ch1 CTL1:CTL0 = 2'b01 during PREAMBLE; 2'b00 otherwise.
  - ch2 is always 2'b00.
  - ch0 carries the syncs in every mode; the encoders ignore ch0 CTL in VIDEO/GUARD.
- pix_x and pix_y equal x and y in VIDEO, and are 0 otherwise.
- Simultaneous events:
  - enable falling on the final wrap pix_ce ends the frame: go to IDLE.
  - rst_in has priority over everything.

Decomposition:
- Shared package hdmi_pkg holds:
  - mode encoding constants MODE_CTRL, MODE_PREAMBLE, MODE_GUARD, MODE_VIDEO;
  - 640x480 timing constants;
  - FSM state encoding.
- One natural sub-module: hdmi_timing_cnt, which contains the x/y counters with pix_ce, hold and wrap, and exposes a wrap_frame strobe. The FSM and decode stay in the top module.

Test Plan:
- Reset then enable=1, pix_ce every 10th clk:
  - first pix_ce gives frame_start=1, busy=1, mode=VIDEO, pix_x=0, pix_y=0;
  - frame_start is high for exactly 1 clk.
- Line 0 scan:
  - x=0..639 gives VIDEO with pix_x=x.
  - x=640..789 gives CTRL.
  - x=790..797 gives PREAMBLE with ctl[3:2]=01.
  - x=798..799 gives GUARD.
  - hsync=0 exactly for x=656..751.
- y=479 line:
  - x=790..799 stay CTRL (next line 480 is inactive).
  - y=524 line shows PREAMBLE at 790..797 and GUARD at 798..799.
  - vsync=0 only on y=490..491.
- Drop enable at (x=100, y=200):
  - frame continues unchanged to (799, 524), then IDLE with busy=0 and mode=CTRL;
  - no frame_start is generated.
  - Re-raise enable at y=300: no break, and frame_start appears at the next wrap.
- Hold pix_ce=0 for 50 clks mid-line: all outputs frozen. Assert rst_in=0 for 1 clk mid-frame: next clk shows the reset values, and x and y restart at 0.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared constants for the 640x480@60 HDMI period scheduler: default
// timing, HDMI period (mode) encoding and FSM state encoding.
package hdmi_pkg;

  // 640x480@60 default timing
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam logic        DEF_SYNC_POL = 1'b0;
  localparam int unsigned DEF_PRE_LEN  = 8;
  localparam int unsigned DEF_GB_LEN   = 2;

  // HDMI period type presented on the mode output
  localparam logic [1:0] MODE_CTRL     = 2'd0;
  localparam logic [1:0] MODE_PREAMBLE = 2'd1;
  localparam logic [1:0] MODE_GUARD    = 2'd2;
  localparam logic [1:0] MODE_VIDEO    = 2'd3;

  // Frame sequencing states; DRAIN finishes the current frame then idles
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/hdmi_timing_cnt.sv
// Horizontal/vertical pixel counters. The owner chooses per pixel enable
// whether to clear, advance or hold; the next (x, y) is exported so the
// owner can register outputs that match the counters with no lag.
module hdmi_timing_cnt #(
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic       clr_i,
  input  logic       adv_i,
  output logic [9:0] x_nxt_o,
  output logic [9:0] y_nxt_o,
  output logic       wrap_frame_o
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;

  // Next position: clear has priority, then advance with line/frame wrap
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Counter registers, moving only on the pixel enable
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else if (ce_i) begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_nxt_o      = x_d;
  assign y_nxt_o      = y_d;
  assign wrap_frame_o = (x_q == H_LAST) && (y_q == V_LAST);

endmodule

// File: rtl/hdmi_period_sched.sv
// HDMI period scheduler: frame start/stop FSM plus per-pixel decode of
// period type, CTL/sync bits and active-pixel coordinates. All outputs are
// registered from the next counter value, so they describe the pixel that
// the counters hold.
//
// Handshake: enable is a level request. A pixel enable with enable=1 in
// IDLE starts a frame (busy rises, frame_start pulses). Dropping enable
// never cuts a frame short: the frame runs to its last pixel and busy
// falls on the pixel enable that would have wrapped. Raising enable again
// before that point continues seamlessly into the next frame.
module hdmi_period_sched
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = DEF_SYNC_POL,
  parameter int unsigned PRE_LEN  = DEF_PRE_LEN,
  parameter int unsigned GB_LEN   = DEF_GB_LEN
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       pix_ce,
  input  logic       enable,
  output logic       busy,
  output logic       frame_start,
  output logic [1:0] mode,
  output logic [5:0] ctl,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HA        = 10'(H_ACTIVE);
  localparam logic [9:0] VA        = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] GB_START  = 10'(H_TOTAL - GB_LEN);
  localparam logic [9:0] PRE_START = 10'(H_TOTAL - GB_LEN - PRE_LEN);
  localparam logic [5:0] CTL_IDLE  = {4'b0000, ~SYNC_POL, ~SYNC_POL};

  state_e     state_q, state_d;
  logic       cnt_clr, cnt_adv, fs_d;
  logic       wrap_frame;
  logic [9:0] x_nxt, y_nxt;

  logic       busy_q, fs_q;
  logic [1:0] mode_q, mode_d;
  logic [5:0] ctl_q, ctl_d;
  logic [9:0] px_q, px_d, py_q, py_d;
  logic [9:0] ny;
  logic       nla, vid, hs_act, vs_act;

  hdmi_timing_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_cnt (
    .clk_i        (clk_in),
    .rst_ni       (rst_in),
    .ce_i         (pix_ce),
    .clr_i        (cnt_clr),
    .adv_i        (cnt_adv),
    .x_nxt_o      (x_nxt),
    .y_nxt_o      (y_nxt),
    .wrap_frame_o (wrap_frame)
  );

  // Next state and counter control; only takes effect on a pixel enable
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    fs_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
          fs_d    = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (wrap_frame && !enable) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_adv = 1'b1;
          fs_d    = wrap_frame;
          state_d = enable ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Decode of the pixel the counters are about to hold
  always_comb begin
    ny     = (y_nxt == V_LAST) ? 10'd0 : y_nxt + 10'd1;
    nla    = (ny < VA);
    vid    = (x_nxt < HA) && (y_nxt < VA);
    hs_act = (x_nxt >= HS_START) && (x_nxt < HS_END);
    vs_act = (y_nxt >= VS_START) && (y_nxt < VS_END);
    mode_d = MODE_CTRL;
    ctl_d  = CTL_IDLE;
    px_d   = '0;
    py_d   = '0;
    if (state_d != ST_IDLE) begin
      if (vid) begin
        mode_d = MODE_VIDEO;
        px_d   = x_nxt;
        py_d   = y_nxt;
      end else if (nla && (x_nxt >= GB_START)) begin
        mode_d = MODE_GUARD;
      end else if (nla && (x_nxt >= PRE_START)) begin
        mode_d = MODE_PREAMBLE;
      end
      ctl_d[0] = hs_act ? SYNC_POL : ~SYNC_POL;
      ctl_d[1] = vs_act ? SYNC_POL : ~SYNC_POL;
      if (mode_d == MODE_PREAMBLE) ctl_d[3:2] = 2'b01;
    end
  end

  // State and output registers; frame_start self-clears between enables
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      fs_q    <= 1'b0;
      mode_q  <= MODE_CTRL;
      ctl_q   <= CTL_IDLE;
      px_q    <= '0;
      py_q    <= '0;
    end else if (pix_ce) begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      fs_q    <= fs_d;
      mode_q  <= mode_d;
      ctl_q   <= ctl_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end else begin
      fs_q    <= 1'b0;
    end
  end

  assign busy        = busy_q;
  assign frame_start = fs_q;
  assign mode        = mode_q;
  assign ctl         = ctl_q;
  assign pix_x       = px_q;
  assign pix_y       = py_q;

endmodule

// File: tb/tb_hdmi_period_sched.sv
// Directed bench for hdmi_period_sched. One instance uses the 640x480
// default timing (first line and a bit); a second uses a tiny 32x12
// geometry with positive syncs so whole frames, drain and restart fit in
// a short run. Expected outputs come from hand-computed pixel ranges.
module tb_hdmi_period_sched;

  logic clk = 1'b0;
  logic rst_in, pix_ce, enable;

  logic       d_busy, d_fs, s_busy, s_fs;
  logic [1:0] d_mode, s_mode;
  logic [5:0] d_ctl, s_ctl;
  logic [9:0] d_px, d_py, s_px, s_py;

  int checks = 0;
  int errors = 0;

  // model positions: d* default instance, s* small instance
  int dx = 0, dy = 0, sx = 0, sy = 0;
  bit drun = 0, dfsm = 0, srun = 0, sfsm = 0;

  // clock / reset block
  always #5 clk = ~clk;

  hdmi_period_sched u_def (
    .clk_in (clk), .rst_in (rst_in), .pix_ce (pix_ce), .enable (enable),
    .busy (d_busy), .frame_start (d_fs), .mode (d_mode), .ctl (d_ctl),
    .pix_x (d_px), .pix_y (d_py)
  );

  hdmi_period_sched #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b1), .PRE_LEN (8), .GB_LEN (2)
  ) u_small (
    .clk_in (clk), .rst_in (rst_in), .pix_ce (pix_ce), .enable (enable),
    .busy (s_busy), .frame_start (s_fs), .mode (s_mode), .ctl (s_ctl),
    .pix_x (s_px), .pix_y (s_py)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // 640x480 default, negative syncs: hsync 656..751, vsync 490..491,
  // no preamble/guard on lines 479..523
  task automatic check_def(input string tag);
    logic [1:0] m; logic [5:0] c; logic [9:0] px, py; bit vid, nla, hs, vs;
    if (!drun) begin
      m = 2'd0; c = 6'b000011; px = 0; py = 0;
    end else begin
      vid = (dx < 640) && (dy < 480);
      nla = !((dy >= 479) && (dy <= 523));
      m = vid ? 2'd3 : (nla && dx >= 798) ? 2'd2 : (nla && dx >= 790) ? 2'd1 : 2'd0;
      hs = !((dx >= 656) && (dx <= 751));
      vs = !((dy == 490) || (dy == 491));
      c = {2'b00, (m == 2'd1) ? 2'b01 : 2'b00, vs, hs};
      px = vid ? 10'(dx) : 10'd0;
      py = vid ? 10'(dy) : 10'd0;
    end
    chk($sformatf("%s def(%0d,%0d) mode", tag, dx, dy), 10'(d_mode), 10'(m));
    chk($sformatf("%s def(%0d,%0d) ctl", tag, dx, dy), 10'(d_ctl), 10'(c));
    chk($sformatf("%s def(%0d,%0d) pix_x", tag, dx, dy), d_px, px);
    chk($sformatf("%s def(%0d,%0d) pix_y", tag, dx, dy), d_py, py);
    chk($sformatf("%s def(%0d,%0d) busy", tag, dx, dy), 10'(d_busy), 10'(drun));
    chk($sformatf("%s def(%0d,%0d) frame_start", tag, dx, dy), 10'(d_fs), 10'(dfsm));
  endtask

  // 32x12 small, positive syncs: hsync 20..25, vsync 8..9, active 16x6,
  // preamble 22..29, guard 30..31 on lines 0..4 and 11
  task automatic check_small(input string tag);
    logic [1:0] m; logic [5:0] c; logic [9:0] px, py; bit vid, nla, hs, vs;
    if (!srun) begin
      m = 2'd0; c = 6'b000000; px = 0; py = 0;
    end else begin
      vid = (sx < 16) && (sy < 6);
      nla = !((sy >= 5) && (sy <= 10));
      m = vid ? 2'd3 : (nla && sx >= 30) ? 2'd2 : (nla && sx >= 22) ? 2'd1 : 2'd0;
      hs = (sx >= 20) && (sx <= 25);
      vs = (sy == 8) || (sy == 9);
      c = {2'b00, (m == 2'd1) ? 2'b01 : 2'b00, vs, hs};
      px = vid ? 10'(sx) : 10'd0;
      py = vid ? 10'(sy) : 10'd0;
    end
    chk($sformatf("%s sml(%0d,%0d) mode", tag, sx, sy), 10'(s_mode), 10'(m));
    chk($sformatf("%s sml(%0d,%0d) ctl", tag, sx, sy), 10'(s_ctl), 10'(c));
    chk($sformatf("%s sml(%0d,%0d) pix_x", tag, sx, sy), s_px, px);
    chk($sformatf("%s sml(%0d,%0d) pix_y", tag, sx, sy), s_py, py);
    chk($sformatf("%s sml(%0d,%0d) busy", tag, sx, sy), 10'(s_busy), 10'(srun));
    chk($sformatf("%s sml(%0d,%0d) frame_start", tag, sx, sy), 10'(s_fs), 10'(sfsm));
  endtask

  task automatic check_both(input string tag);
    check_def(tag);
    check_small(tag);
  endtask

  // expected position after one pixel enable
  task automatic adv_model(inout int x, inout int y, inout bit run, inout bit fs,
                           input int hl, input int vl);
    if (!run) begin
      if (enable) begin run = 1; x = 0; y = 0; fs = 1; end
      else fs = 0;
    end else if (x == hl && y == vl) begin
      if (enable) begin x = 0; y = 0; fs = 1; end
      else begin run = 0; x = 0; y = 0; fs = 0; end
    end else begin
      fs = 0;
      if (x == hl) begin x = 0; y++; end
      else x++;
    end
  endtask

  // driver: one pixel enable followed by nine idle clocks
  task automatic ce_step();
    @(negedge clk) pix_ce = 1'b1;
    @(posedge clk);
    #1;
    pix_ce = 1'b0;
    adv_model(dx, dy, drun, dfsm, 799, 524);
    adv_model(sx, sy, srun, sfsm, 31, 11);
    check_both("ce");
    @(posedge clk);
    #1;
    dfsm = 0;
    sfsm = 0;
    check_both("after");
    repeat (8) @(posedge clk);
  endtask

  initial begin
    rst_in = 1'b0;
    pix_ce = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_both("reset");

    // idle with enable low: nothing starts
    @(negedge clk) rst_in = 1'b1;
    ce_step();

    // start and scan line 0 of the default timing, two-plus small frames
    enable = 1'b1;
    for (int i = 0; i < 820; i++) ce_step();

    // pixel enable held low mid-line: everything frozen
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      check_both("frozen");
    end

    // one-clock reset mid-frame aborts immediately
    @(negedge clk) rst_in = 1'b0;
    @(posedge clk);
    #1;
    drun = 0; dx = 0; dy = 0; dfsm = 0;
    srun = 0; sx = 0; sy = 0; sfsm = 0;
    check_both("midrst");
    @(negedge clk) rst_in = 1'b1;

    // restart, drop enable mid-frame, re-raise before the end
    for (int n = 0; n < 1000 && !(srun && sx == 5 && sy == 2); n++) ce_step();
    enable = 1'b0;
    for (int n = 0; n < 1000 && sy != 4; n++) ce_step();
    enable = 1'b1;
    for (int n = 0; n < 1000 && !(sx == 0 && sy == 0); n++) ce_step();

    // drop enable and leave it low: frame finishes, then IDLE
    for (int n = 0; n < 1000 && !(sx == 5 && sy == 2); n++) ce_step();
    enable = 1'b0;
    for (int n = 0; n < 1000 && srun; n++) ce_step();
    for (int i = 0; i < 5; i++) ce_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
